// File: rtl/video_axis_checker.sv
// Video AXI4-Stream geometry checker.
// Passes the stream through untouched and watches SOF (tuser) / EOL (tlast)
// against the expected H_ACTIVE x V_ACTIVE geometry, reporting frame
// completion, lock status and sticky protocol errors.
//
// state    | meaning
// WAIT_SOF | idle between frames; beats are ignored until one carries tuser
// ACTIVE   | inside a frame; pixels and lines are being counted
module video_axis_checker #(
  parameter int DATAW    = 32,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [DATAW-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic             clr,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err_short,
  output logic             err_long,
  output logic             err_sof
);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  localparam logic [12:0] H_LEN  = 13'(H_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

  state_t      state;
  logic [11:0] pix_cnt;
  logic [10:0] line_cnt;
  logic        frame_err;
  logic [1:0]  rst_sync;
  logic        run;

  logic        beat;
  logic        in_frame;
  logic        sof_ev;
  logic        short_ev;
  logic        long_ev;
  logic        eol;
  logic        frame_end;
  logic        frame_err_now;
  logic [11:0] base_pix;
  logic [10:0] base_line;
  logic [12:0] pix_next;

  // Zero-latency pass-through; the checker never stalls the stream.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign s_axis_tready = m_axis_tready;

  // Reset asserts immediately, releases two clean edges later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // Beat classification; a SOF beat restarts counting from pixel 0 of line 0.
  always_comb begin
    beat          = 1'b0;
    in_frame      = 1'b0;
    sof_ev        = 1'b0;
    short_ev      = 1'b0;
    long_ev       = 1'b0;
    eol           = 1'b0;
    frame_end     = 1'b0;
    frame_err_now = 1'b0;
    base_pix      = pix_cnt;
    base_line     = line_cnt;
    pix_next      = 13'd0;

    beat     = s_axis_tvalid && m_axis_tready && run;
    in_frame = beat && ((state == ACTIVE) || s_axis_tuser);
    sof_ev   = beat && s_axis_tuser && (state == ACTIVE);

    if (s_axis_tuser) begin
      base_pix  = 12'd0;
      base_line = 11'd0;
    end
    pix_next = {1'b0, base_pix} + 13'd1;

    short_ev  = in_frame && s_axis_tlast && (pix_next < H_LEN);
    long_ev   = in_frame && !s_axis_tlast && (pix_next == H_LEN);
    eol       = in_frame && (s_axis_tlast || (pix_next == H_LEN));
    frame_end = eol && (base_line == V_LAST);

    frame_err_now = (s_axis_tuser ? 1'b0 : frame_err) | sof_ev | short_ev | long_ev;
  end

  // Frame tracking, status and sticky error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= WAIT_SOF;
      pix_cnt    <= 12'd0;
      line_cnt   <= 11'd0;
      frame_err  <= 1'b0;
      frame_cnt  <= 16'd0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= frame_end;

      err_short <= short_ev | (err_short & ~clr);
      err_long  <= long_ev  | (err_long  & ~clr);
      err_sof   <= sof_ev   | (err_sof   & ~clr);

      if (clr)            frame_cnt <= 16'd0;
      else if (frame_end) frame_cnt <= frame_cnt + 16'd1;

      if (frame_end)   locked <= ~frame_err_now;
      else if (sof_ev) locked <= 1'b0;

      if (in_frame) begin
        frame_err <= frame_err_now;
        if (eol) begin
          pix_cnt <= 12'd0;
          if (frame_end) begin
            line_cnt <= 11'd0;
            state    <= WAIT_SOF;
          end else begin
            line_cnt <= base_line + 11'd1;
            state    <= ACTIVE;
          end
        end else begin
          pix_cnt  <= pix_next[11:0];
          line_cnt <= base_line;
          state    <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_axis_checker.sv
// Directed bench for video_axis_checker with an 8x4 frame geometry.
module tb_video_axis_checker;

  localparam int DATAW = 32;
  localparam int H     = 8;
  localparam int V     = 4;

  logic             clk;
  logic             rstn;
  logic [DATAW-1:0] s_tdata;
  logic             s_tvalid, s_tuser, s_tlast, s_tready;
  logic [DATAW-1:0] m_tdata;
  logic             m_tvalid, m_tuser, m_tlast, m_tready;
  logic             clr;
  logic             locked, frame_done, err_short, err_long, err_sof;
  logic [15:0]      frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  video_axis_checker #(.DATAW(DATAW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .clr(clr), .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_short(err_short), .err_long(err_long), .err_sof(err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, r, u, l, c, chk;
    logic        e_done, e_lock, e_short, e_long, e_sof;
    logic [15:0] e_cnt;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  task automatic chk_all(input string n, input logic d, input logic lk, input logic [15:0] cnt,
                         input logic s, input logic lo, input logic so);
    cmp({n, ".frame_done"}, 32'(frame_done), 32'(d));
    cmp({n, ".locked"},     32'(locked),     32'(lk));
    cmp({n, ".frame_cnt"},  32'(frame_cnt),  32'(cnt));
    cmp({n, ".err_short"},  32'(err_short),  32'(s));
    cmp({n, ".err_long"},   32'(err_long),   32'(lo));
    cmp({n, ".err_sof"},    32'(err_sof),    32'(so));
  endtask

  function automatic void push_raw(input logic v, input logic r, input logic u,
                                   input logic l, input logic c);
    vec_t t;
    t.v = v; t.r = r; t.u = u; t.l = l; t.c = c; t.chk = 1'b0;
    t.e_done = 1'b0; t.e_lock = 1'b0; t.e_short = 1'b0; t.e_long = 1'b0; t.e_sof = 1'b0;
    t.e_cnt = 16'd0; t.name = "";
    vecs.push_back(t);
  endfunction

  function automatic void push_beat(input logic u, input logic l, input logic c = 1'b0);
    push_raw(1'b1, 1'b1, u, l, c);
  endfunction

  function automatic void push_line(input logic first_user, input int n, input logic with_last);
    for (int i = 0; i < n; i++)
      push_beat(first_user && (i == 0), with_last && (i == n - 1));
  endfunction

  function automatic void push_good_lines(input int n);
    for (int i = 0; i < n; i++) push_line(1'b0, H, 1'b1);
  endfunction

  // Expected outputs after the clock edge that consumes the last pushed record.
  function automatic void mark(input string n, input logic d, input logic lk, input logic [15:0] cnt,
                               input logic s, input logic lo, input logic so);
    int k;
    k = vecs.size() - 1;
    vecs[k].chk = 1'b1; vecs[k].name = n;
    vecs[k].e_done = d; vecs[k].e_lock = lk; vecs[k].e_cnt = cnt;
    vecs[k].e_short = s; vecs[k].e_long = lo; vecs[k].e_sof = so;
  endfunction

  task automatic drive_beat(input logic u, input logic l);
    s_tvalid = 1'b1; m_tready = 1'b1; s_tuser = u; s_tlast = l; s_tdata = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; clr = 1'b0; m_tready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pass-through must hold on every cycle, regardless of state.
  always @(negedge clk) begin
    cmp("pass_data",  m_tdata, s_tdata);
    cmp("pass_ctrl",  {29'd0, m_tvalid, m_tuser, m_tlast}, {29'd0, s_tvalid, s_tuser, s_tlast});
    cmp("pass_ready", 32'(s_tready), 32'(m_tready));
  end

  initial begin
    logic tr;
    logic done_b;

    // Frame 1 with stalls mid-line (valid low, then ready low)
    push_line(1'b1, 4, 1'b0);
    push_raw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_raw(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push_line(1'b0, 4, 1'b1);
    push_good_lines(V - 1);
    mark("f1_end", 1, 1, 1, 0, 0, 0);
    // Frame 2
    push_beat(1'b1, 1'b0);
    mark("f1_pulse_gone", 0, 1, 1, 0, 0, 0);
    push_line(1'b0, H - 1, 1'b1);
    push_good_lines(V - 1);
    mark("f2_end", 1, 1, 2, 0, 0, 0);
    // Frame 3: early tlast at pixel 5 of line 1
    push_line(1'b1, H, 1'b1);
    push_line(1'b0, 6, 1'b1);
    mark("short_flag", 0, 1, 2, 1, 0, 0);
    push_good_lines(2);
    mark("f3_end", 1, 0, 3, 1, 0, 0);
    // Frame 4: good, short stays sticky
    push_line(1'b1, H, 1'b1);
    push_good_lines(V - 1);
    mark("f4_end", 1, 1, 4, 1, 0, 0);
    // Frame 5: SOF at pixel 3 of line 2, then 32 beats of restarted frame
    push_line(1'b1, H, 1'b1);
    push_good_lines(1);
    push_line(1'b0, 3, 1'b0);
    push_beat(1'b1, 1'b0);
    mark("sof_flag", 0, 0, 4, 1, 0, 1);
    push_line(1'b0, H - 1, 1'b1);
    push_good_lines(V - 1);
    mark("restart_end", 1, 0, 5, 1, 0, 1);
    // Frame 6: good
    push_line(1'b1, H, 1'b1);
    push_good_lines(V - 1);
    mark("f6_end", 1, 1, 6, 1, 0, 1);
    // Beats without SOF while waiting are ignored
    push_beat(1'b0, 1'b1);
    push_beat(1'b0, 1'b0);
    mark("ignore_wait", 0, 1, 6, 1, 0, 1);
    // clr coincides with err_long (missing tlast at pixel 7)
    push_line(1'b1, H - 1, 1'b0);
    push_beat(1'b0, 1'b0, 1'b1);
    mark("clr_vs_long", 0, 1, 0, 0, 1, 0);
    push_good_lines(V - 1);
    mark("long_frame_end", 1, 0, 1, 0, 1, 0);
    // clr coincides with a clean frame end
    push_line(1'b1, H, 1'b1);
    push_good_lines(V - 2);
    push_line(1'b0, H - 1, 1'b0);
    push_beat(1'b0, 1'b1, 1'b1);
    mark("clr_vs_end", 1, 1, 0, 0, 0, 0);
    // SOF and tlast on the same beat inside a frame
    push_line(1'b1, 3, 1'b0);
    push_beat(1'b1, 1'b1);
    mark("sof_and_last", 0, 0, 0, 1, 0, 1);
    push_good_lines(V - 1);
    mark("sof_last_end", 1, 0, 1, 1, 0, 1);

    // Reset
    rstn = 1'b0; clr = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; m_tready = 1'b1;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(3);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      s_tvalid = vecs[i].v; m_tready = vecs[i].r; s_tuser = vecs[i].u;
      s_tlast = vecs[i].l; clr = vecs[i].c; s_tdata = $urandom;
      @(posedge clk); #1;
      if (vecs[i].chk)
        chk_all(vecs[i].name, vecs[i].e_done, vecs[i].e_lock, vecs[i].e_cnt,
                vecs[i].e_short, vecs[i].e_long, vecs[i].e_sof);
    end
    idle(2);

    // Ready toggling each cycle with valid held high
    tr = 1'b0;
    for (int b = 0; b < H * V; b++) begin
      s_tvalid = 1'b1; s_tuser = (b == 0); s_tlast = ((b % H) == H - 1); s_tdata = $urandom;
      done_b = 1'b0;
      for (int t = 0; t < 4 && !done_b; t++) begin
        tr = ~tr; m_tready = tr;
        @(posedge clk); #1;
        if (tr) done_b = 1'b1;
      end
      cmp("toggle_handshake", 32'(done_b), 32'd1);
      if (b == H * V - 2) cmp("toggle_cnt_31", 32'(frame_cnt), 32'd1);
    end
    chk_all("toggle_end", 1, 1, 2, 1, 0, 1);
    idle(2);

    // Reset asserted mid-frame
    drive_beat(1'b1, 1'b0);
    for (int i = 1; i < 2 * H + 3; i++) drive_beat(1'b0, (i % H) == H - 1);
    #2 rstn = 1'b0;
    #1;
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b1);
    #1 rstn = 1'b1;
    idle(3);
    drive_beat(1'b0, 1'b1);
    chk_all("post_reset_ignore", 0, 0, 0, 0, 0, 0);
    drive_beat(1'b1, 1'b0);
    for (int i = 1; i < H * V; i++) drive_beat(1'b0, (i % H) == H - 1);
    chk_all("post_reset_frame", 1, 1, 1, 0, 0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
